// File: rtl/a_b_req_pkg.sv
// Shared widths, request record and FSM state encoding for the A/B request sink.
package a_b_req_pkg;

  localparam int ADDR_W = 12;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 24;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } req_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/a_b_req_fifo.sv
// Flop-based request FIFO with a combinational head. Zero-latency read, one-cycle write.
// A push while full is ignored unless a pop happens in the same cycle.
module a_b_req_fifo
  import a_b_req_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  req_t                     push_dat,
  input  logic                     pop,
  output req_t                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  req_t          mem_q [DEPTH];
  req_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    do_pop   = pop && !empty;
    // Freeing a slot in the same cycle makes room for a push into a full FIFO.
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/a_b_req_sink.sv
// Binds queued A-side requests to B-side data beats and emits sequential memory writes.
// Outputs registered (latency 1); never stalls: orphan beats and overflowing requests are flagged and dropped.
module a_b_req_sink
  import a_b_req_pkg::*;
#(
  parameter int REQ_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         Valid_Addr,
  input  logic [11:0]                  Address,
  input  logic [3:0]                   Length,
  input  logic                         Valid_Data,
  input  logic [23:0]                  Data,
  output logic                         wr_en,
  output logic [11:0]                  wr_addr,
  output logic [23:0]                  wr_data,
  output logic                         burst_done,
  output logic                         busy,
  output logic [$clog2(REQ_DEPTH):0]   req_count,
  output logic                         err_orphan,
  output logic                         err_overflow
);

  localparam int CW = $clog2(REQ_DEPTH) + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  beats_left_q, beats_left_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              burst_done_q, burst_done_d;
  logic              busy_q, busy_d;
  logic              err_orphan_q, err_orphan_d;
  logic              err_overflow_q, err_overflow_d;

  req_t          fifo_head, take_req, in_req;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_next;
  logic          push, pop, take, bypass, push_ok;

  assign in_req = '{addr: Address, len: Length};

  a_b_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (in_req),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_d        = state_q;
    cur_addr_d     = cur_addr_q;
    beats_left_d   = beats_left_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    burst_done_d   = 1'b0;
    err_orphan_d   = 1'b0;
    take           = 1'b0;
    bypass         = 1'b0;
    pop            = 1'b0;
    take_req       = fifo_head;

    case (state_q)
      IDLE: begin
        if (Valid_Data) begin
          if (!fifo_empty) begin
            take = 1'b1;
            pop  = 1'b1;
          end else if (Valid_Addr) begin
            // Request and its first beat arrive together: skip the queue.
            take     = 1'b1;
            bypass   = 1'b1;
            take_req = in_req;
          end else begin
            err_orphan_d = 1'b1;
          end
        end
        if (take) begin
          wr_en_d   = 1'b1;
          wr_addr_d = take_req.addr;
          wr_data_d = Data;
          if (take_req.len == '0) begin
            burst_done_d = 1'b1;
          end else begin
            state_d      = ACTIVE;
            cur_addr_d   = take_req.addr + 1'b1;
            beats_left_d = take_req.len;
          end
        end
      end
      ACTIVE: begin
        if (Valid_Data) begin
          wr_en_d      = 1'b1;
          wr_addr_d    = cur_addr_q;
          wr_data_d    = Data;
          cur_addr_d   = cur_addr_q + 1'b1;
          beats_left_d = beats_left_q - 1'b1;
          if (beats_left_q == LEN_W'(1)) begin
            burst_done_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    push           = Valid_Addr && !bypass;
    push_ok        = push && (!fifo_full || pop);
    err_overflow_d = push && !push_ok;
    count_next     = fifo_count + CW'(push_ok) - CW'(pop);
    busy_d         = (state_d == ACTIVE) || (count_next != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cur_addr_q     <= '0;
      beats_left_q   <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      burst_done_q   <= 1'b0;
      busy_q         <= 1'b0;
      err_orphan_q   <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_addr_q     <= cur_addr_d;
      beats_left_q   <= beats_left_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      burst_done_q   <= burst_done_d;
      busy_q         <= busy_d;
      err_orphan_q   <= err_orphan_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign burst_done   = burst_done_q;
  assign busy         = busy_q;
  assign req_count    = fifo_count;
  assign err_orphan   = err_orphan_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_a_b_req_sink.sv
// Directed bench for a_b_req_sink with hand-computed expectations.
module tb_a_b_req_sink;

  logic        clk;
  logic        rst_n;
  logic        Valid_Addr;
  logic [11:0] Address;
  logic [3:0]  Length;
  logic        Valid_Data;
  logic [23:0] Data;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [23:0] wr_data;
  logic        burst_done;
  logic        busy;
  logic [2:0]  req_count;
  logic        err_orphan;
  logic        err_overflow;

  int n_cmp;
  int n_bad;

  a_b_req_sink #(.REQ_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Valid_Addr   (Valid_Addr),
    .Address      (Address),
    .Length       (Length),
    .Valid_Data   (Valid_Data),
    .Data         (Data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .burst_done   (burst_done),
    .busy         (busy),
    .req_count    (req_count),
    .err_orphan   (err_orphan),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and return 1 time unit after the edge.
  task automatic step(input logic va, input logic [11:0] a, input logic [3:0] l,
                      input logic vd, input logic [23:0] d);
    Valid_Addr = va;
    Address    = a;
    Length     = l;
    Valid_Data = vd;
    Data       = d;
    @(posedge clk);
    #1;
    Valid_Addr = 1'b0;
    Valid_Data = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic [11:0] a, input logic [23:0] d,
                        input logic done);
    chk({tag, ".wr_en"},      32'(wr_en),      32'd1);
    chk({tag, ".wr_addr"},    32'(wr_addr),    32'(a));
    chk({tag, ".wr_data"},    32'(wr_data),    32'(d));
    chk({tag, ".burst_done"}, 32'(burst_done), 32'(done));
  endtask

  logic [11:0] wrap_addr [4];
  logic [11:0] q_addr    [5];

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    Valid_Addr = 1'b0;
    Address    = '0;
    Length     = '0;
    Valid_Data = 1'b0;
    Data       = '0;
    wrap_addr  = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    q_addr     = '{12'h100, 12'h110, 12'h120, 12'h130, 12'h140};

    repeat (2) @(posedge clk);
    #1;
    chk("rst.wr_en",        32'(wr_en),        32'd0);
    chk("rst.wr_addr",      32'(wr_addr),      32'd0);
    chk("rst.wr_data",      32'(wr_data),      32'd0);
    chk("rst.burst_done",   32'(burst_done),   32'd0);
    chk("rst.busy",         32'(busy),         32'd0);
    chk("rst.req_count",    32'(req_count),    32'd0);
    chk("rst.err_orphan",   32'(err_orphan),   32'd0);
    chk("rst.err_overflow", 32'(err_overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single queued request of 4 beats, with one idle gap inside the burst.
    step(1'b1, 12'h010, 4'd3, 1'b0, 24'h0);
    chk("t1.req.wr_en",     32'(wr_en),     32'd0);
    chk("t1.req.req_count", 32'(req_count), 32'd1);
    chk("t1.req.busy",      32'(busy),      32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 12'h0, 4'd0, 1'b1, 24'hA0 + 24'(i));
      chk_wr($sformatf("t1.beat%0d", i), 12'h010 + 12'(i), 24'hA0 + 24'(i), i == 3);
      chk($sformatf("t1.beat%0d.req_count", i), 32'(req_count), 32'd0);
      if (i == 1) begin
        step(1'b0, 12'h0, 4'd0, 1'b0, 24'h0);
        chk("t1.gap.wr_en", 32'(wr_en), 32'd0);
        chk("t1.gap.busy",  32'(busy),  32'd1);
      end
    end
    chk("t1.end.busy", 32'(busy), 32'd0);
    step(1'b0, 12'h0, 4'd0, 1'b0, 24'h0);
    chk("t1.idle.wr_en",      32'(wr_en),      32'd0);
    chk("t1.idle.burst_done", 32'(burst_done), 32'd0);

    // Request and its only beat in the same cycle.
    step(1'b1, 12'h200, 4'd0, 1'b1, 24'h123456);
    chk_wr("t2.bypass", 12'h200, 24'h123456, 1'b1);
    chk("t2.req_count", 32'(req_count), 32'd0);
    chk("t2.busy",      32'(busy),      32'd0);

    // Address wrap at the top of the 12-bit space.
    step(1'b1, 12'hFFE, 4'd3, 1'b0, 24'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 12'h0, 4'd0, 1'b1, 24'h000C00 + 24'(i));
      chk_wr($sformatf("t3.wrap%0d", i), wrap_addr[i], 24'h000C00 + 24'(i), i == 3);
    end

    // Fill the FIFO, overflow once, then accept the 5th alongside a completing pop.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, q_addr[i], 4'd0, 1'b0, 24'h0);
      chk($sformatf("t4.fill%0d.req_count", i), 32'(req_count), 32'(i + 1));
    end
    step(1'b1, q_addr[4], 4'd0, 1'b0, 24'h0);
    chk("t4.ovf.err_overflow", 32'(err_overflow), 32'd1);
    chk("t4.ovf.req_count",    32'(req_count),    32'd4);
    step(1'b0, 12'h0, 4'd0, 1'b0, 24'h0);
    chk("t4.ovf.pulse_end", 32'(err_overflow), 32'd0);
    step(1'b1, q_addr[4], 4'd0, 1'b1, 24'h55);
    chk_wr("t4.pop", q_addr[0], 24'h55, 1'b1);
    chk("t4.pop.err_overflow", 32'(err_overflow), 32'd0);
    chk("t4.pop.req_count",    32'(req_count),    32'd4);
    for (int i = 1; i < 5; i++) begin
      step(1'b0, 12'h0, 4'd0, 1'b1, 24'h60 + 24'(i));
      chk_wr($sformatf("t4.drain%0d", i), q_addr[i], 24'h60 + 24'(i), 1'b1);
      chk($sformatf("t4.drain%0d.req_count", i), 32'(req_count), 32'(4 - i));
    end
    chk("t4.end.busy", 32'(busy), 32'd0);

    // Orphan beat.
    step(1'b0, 12'h0, 4'd0, 1'b1, 24'hDEAD);
    chk("t5.err_orphan", 32'(err_orphan), 32'd1);
    chk("t5.wr_en",      32'(wr_en),      32'd0);
    step(1'b0, 12'h0, 4'd0, 1'b0, 24'h0);
    chk("t5.pulse_end", 32'(err_orphan), 32'd0);

    // Reset in the middle of an 8-beat burst.
    step(1'b1, 12'h040, 4'd7, 1'b0, 24'h0);
    step(1'b0, 12'h0, 4'd0, 1'b1, 24'hB0);
    chk_wr("t6.beat0", 12'h040, 24'hB0, 1'b0);
    step(1'b0, 12'h0, 4'd0, 1'b1, 24'hB1);
    chk_wr("t6.beat1", 12'h041, 24'hB1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.rst.wr_en",      32'(wr_en),      32'd0);
    chk("t6.rst.wr_addr",    32'(wr_addr),    32'd0);
    chk("t6.rst.wr_data",    32'(wr_data),    32'd0);
    chk("t6.rst.busy",       32'(busy),       32'd0);
    chk("t6.rst.req_count",  32'(req_count),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 12'h0, 4'd0, 1'b1, 24'hB2);
    chk("t6.after.err_orphan", 32'(err_orphan), 32'd1);
    chk("t6.after.wr_en",      32'(wr_en),      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
